// File: rtl/upg_mode_ctrl.sv
// Run/program mode controller: debounces start_pg and sequences the CPU between RUN and
// UART-programming modes, driving the stretched CPU reset and the programmer reset.
module upg_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned RST_STRETCH     = 3
) (
    input  logic       fpga_clk,
    input  logic       fpga_rst,
    input  logic       start_pg,
    input  logic       upg_done_i,
    output logic       start_pulse_o,
    output logic       mode_o,
    output logic       cpu_rst_o,
    output logic       upg_rst_o,
    output logic [1:0] state_o
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned StW = $clog2(RST_STRETCH + 1);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [StW-1:0] StLoad = StW'(RST_STRETCH);
    localparam logic [StW-1:0] StOne  = StW'(1);

    typedef enum logic [1:0] {
        StRstHold = 2'b00,
        StRun     = 2'b01,
        StProg    = 2'b10,
        StDrain   = 2'b11
    } state_e;

    logic [1:0]     sync_q;
    logic           level_q, level_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           start_pulse_q, start_pulse_d;

    state_e         state_q, state_d;
    logic [StW-1:0] st_cnt_q, st_cnt_d;
    logic           mode_q, mode_d;
    logic           cpu_rst_q, cpu_rst_d;
    logic           upg_rst_q, upg_rst_d;

    // Two-flop synchroniser; start_pg is used nowhere else.
    always_ff @(posedge fpga_clk or posedge fpga_rst) begin
        if (fpga_rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], start_pg};
        end
    end

    // Any return to the accepted level restarts the stability count.
    always_comb begin
        level_d       = level_q;
        db_cnt_d      = '0;
        start_pulse_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (db_cnt_q == DbLast) begin
                level_d       = sync_q[1];
                start_pulse_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge fpga_clk or posedge fpga_rst) begin
        if (fpga_rst) begin
            level_q       <= 1'b0;
            db_cnt_q      <= '0;
            start_pulse_q <= 1'b0;
        end else begin
            level_q       <= level_d;
            db_cnt_q      <= db_cnt_d;
            start_pulse_q <= start_pulse_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        st_cnt_d = st_cnt_q;
        unique case (state_q)
            StRstHold, StDrain: begin
                if (st_cnt_q == StOne) begin
                    state_d = StRun;
                end else begin
                    st_cnt_d = st_cnt_q - 1'b1;
                end
            end
            StRun: begin
                if (start_pulse_q) begin
                    state_d = StProg;
                end
            end
            StProg: begin
                // Completion and user abort both drain; coincident events drain once.
                if (upg_done_i || start_pulse_q) begin
                    state_d  = StDrain;
                    st_cnt_d = StLoad;
                end
            end
            default: begin
                state_d  = StRstHold;
                st_cnt_d = StLoad;
            end
        endcase

        // Outputs decode the next state so they move on the same edge as the state.
        mode_d    = (state_d == StProg);
        cpu_rst_d = (state_d != StRun);
        upg_rst_d = (state_d != StProg);
    end

    always_ff @(posedge fpga_clk or posedge fpga_rst) begin
        if (fpga_rst) begin
            state_q   <= StRstHold;
            st_cnt_q  <= StLoad;
            mode_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
            upg_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            st_cnt_q  <= st_cnt_d;
            mode_q    <= mode_d;
            cpu_rst_q <= cpu_rst_d;
            upg_rst_q <= upg_rst_d;
        end
    end

    assign start_pulse_o = start_pulse_q;
    assign mode_o        = mode_q;
    assign cpu_rst_o     = cpu_rst_q;
    assign upg_rst_o     = upg_rst_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_upg_mode_ctrl.sv
// Scoreboard bench for upg_mode_ctrl: expected output vectors are queued as each cycle is
// driven and compared on the following falling edge.
module tb_upg_mode_ctrl;

    // Vector layout: {state[1:0], mode, cpu_rst, upg_rst, start_pulse}
    localparam logic [5:0] ExpHold   = 6'b00_0_1_1_0;
    localparam logic [5:0] ExpRun    = 6'b01_0_0_1_0;
    localparam logic [5:0] ExpRunP   = 6'b01_0_0_1_1;
    localparam logic [5:0] ExpProg   = 6'b10_1_1_0_0;
    localparam logic [5:0] ExpProgP  = 6'b10_1_1_0_1;
    localparam logic [5:0] ExpDrain  = 6'b11_0_1_1_0;
    localparam logic [5:0] ExpDrainP = 6'b11_0_1_1_1;

    logic       fpga_clk = 1'b0;
    logic       fpga_rst = 1'b0;
    logic       start_pg = 1'b0;
    logic       upg_done_i = 1'b0;
    logic       start_pulse_o;
    logic       mode_o;
    logic       cpu_rst_o;
    logic       upg_rst_o;
    logic [1:0] state_o;
    logic [5:0] obs;

    int n_vec = 0;
    int n_err = 0;

    logic [5:0] exp_q[$];
    string      tag_q[$];

    upg_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RST_STRETCH    (3)
    ) dut (
        .fpga_clk     (fpga_clk),
        .fpga_rst     (fpga_rst),
        .start_pg     (start_pg),
        .upg_done_i   (upg_done_i),
        .start_pulse_o(start_pulse_o),
        .mode_o       (mode_o),
        .cpu_rst_o    (cpu_rst_o),
        .upg_rst_o    (upg_rst_o),
        .state_o      (state_o)
    );

    always #5 fpga_clk = ~fpga_clk;

    assign obs = {state_o, mode_o, cpu_rst_o, upg_rst_o, start_pulse_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs settled after the preceding rising edge are compared here.
    always @(negedge fpga_clk) begin
        if (exp_q.size() != 0) begin
            check(tag_q.pop_front(), {26'd0, obs}, {26'd0, exp_q.pop_front()});
        end
    end

    // exp is the output vector after this rising edge; sp/done take effect at the next one.
    task automatic cyc(input logic sp, input logic done, input logic [5:0] exp,
                       input string tag);
        @(posedge fpga_clk);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        start_pg   = sp;
        upg_done_i = done;
    endtask

    task automatic run(input int n, input logic sp, input logic [5:0] exp, input string tag);
        for (int i = 0; i < n; i++) begin
            cyc(sp, 1'b0, exp, tag);
        end
    endtask

    // Press from RUN into PROG, then release while in PROG.
    task automatic enter_prog(input string tag);
        run(6, 1'b1, ExpRun, {tag, "_wait"});
        run(1, 1'b1, ExpRunP, {tag, "_pulse"});
        run(3, 1'b1, ExpProg, {tag, "_prog"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #1 fpga_rst = 1'b1;
        #1 check("reset_async", {26'd0, obs}, {26'd0, ExpHold});
        repeat (2) @(posedge fpga_clk);
        #1 check("reset_held", {26'd0, obs}, {26'd0, ExpHold});
        #2 fpga_rst = 1'b0;

        // Reset stretch
        run(2, 1'b0, ExpHold, "t1_hold");
        run(1, 1'b0, ExpRun, "t1_run");

        // Bouncing button never long enough to be accepted
        for (int i = 0; i < 24; i++) begin
            cyc(((i >> 1) & 1) == 0, 1'b0, ExpRun, "t2_bounce");
        end
        run(8, 1'b0, ExpRun, "t2_idle");

        // Clean press held 20 cycles, then released in PROG (no pulse on release)
        run(6, 1'b1, ExpRun, "t3_wait");
        run(1, 1'b1, ExpRunP, "t3_pulse");
        run(13, 1'b1, ExpProg, "t3_prog");
        run(10, 1'b0, ExpProg, "t3_release");

        // Programmer completion
        cyc(1'b0, 1'b1, ExpProg, "t4_done");
        run(3, 1'b0, ExpDrain, "t4_drain");
        run(3, 1'b0, ExpRun, "t4_run");

        // upg_done coincident with start pulse drains once
        enter_prog("t5a");
        run(10, 1'b0, ExpProg, "t5a_release");
        run(6, 1'b1, ExpProg, "t5a_repress");
        cyc(1'b1, 1'b1, ExpProgP, "t5a_coinc");
        run(3, 1'b1, ExpDrain, "t5a_drain");
        run(4, 1'b1, ExpRun, "t5a_held");
        run(10, 1'b0, ExpRun, "t5a_release2");

        // Press landing in DRAIN is ignored
        enter_prog("t5b");
        run(10, 1'b0, ExpProg, "t5b_release");
        run(4, 1'b1, ExpProg, "t5b_repress");
        cyc(1'b1, 1'b1, ExpProg, "t5b_done");
        run(1, 1'b1, ExpDrain, "t5b_drain");
        run(1, 1'b1, ExpDrainP, "t5b_pulse_drain");
        run(1, 1'b1, ExpDrain, "t5b_drain_end");
        run(5, 1'b1, ExpRun, "t5b_run");
        run(10, 1'b0, ExpRun, "t5b_release2");

        // Asynchronous reset while in PROG
        enter_prog("t6");
        @(negedge fpga_clk);
        #2;
        fpga_rst = 1'b1;
        start_pg = 1'b0;
        #1 check("t6_rst_async", {26'd0, obs}, {26'd0, ExpHold});
        repeat (2) @(posedge fpga_clk);
        #1 check("t6_rst_held", {26'd0, obs}, {26'd0, ExpHold});
        #2 fpga_rst = 1'b0;
        run(2, 1'b0, ExpHold, "t6_hold");
        run(1, 1'b0, ExpRun, "t6_run");
        run(3, 1'b0, ExpRun, "t6_idle");

        @(negedge fpga_clk);
        #1 check("sb_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
